// File: rtl/rx_pkt_fifo.sv
// Packet-atomic RX buffer: a contiguous rx_vld run becomes one packet, visible to reads only once committed.
// Read latency 1 cycle; registered rx_almost_full throttles the mux, and packets that still overflow are dropped whole.
module rx_pkt_fifo #(
   parameter int AW     = 8,
   parameter int AF_GAP = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          reg_flush,
   input  logic          rx_vld,
   input  logic [31:0]   rx_dat,
   output logic          rx_almost_full,
   input  logic          rd_en,
   output logic [31:0]   rd_dat,
   output logic [AW:0]   rd_cnt,
   output logic [15:0]   pkt_cnt,
   output logic [15:0]   drop_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   logic [31:0]  r_mem [0:(1<<AW)-1];
   state_t       r_state;
   state_t       w_state_nxt;
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_cm_ptr;
   logic [AW:0]  r_rd_ptr;
   logic         r_ovf;
   logic         r_af;
   logic [31:0]  r_rd_dat;
   logic [15:0]  r_pkt_cnt;
   logic [15:0]  r_drop_cnt;

   logic [AW:0]  w_used;
   logic [AW:0]  w_free;
   logic [AW:0]  w_rd_cnt;
   logic         w_full;
   logic         w_af_nxt;
   logic         w_wr_en;
   logic         w_commit;
   logic         w_rewind;
   logic         w_ovf_set;
   logic         w_pop;

   // Pointers carry one extra bit so full (used == DEPTH) is distinct from empty.
   assign w_used   = r_wr_ptr - r_rd_ptr;
   assign w_free   = DEPTH - w_used;
   assign w_rd_cnt = r_cm_ptr - r_rd_ptr;
   assign w_full   = (w_used == DEPTH);
   assign w_af_nxt = (32'(w_free) <= 32'(AF_GAP));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (reg_flush) begin
         w_state_nxt = rx_vld ? S_DROP : S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (rx_vld) w_state_nxt = w_full ? S_DROP : S_RECV;
            S_RECV:  if (rx_vld) w_state_nxt = w_full ? S_DROP : S_RECV;
                     else        w_state_nxt = S_IDLE;
            S_DROP:  if (!rx_vld) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_wr_en   = 1'b0;
      w_commit  = 1'b0;
      w_rewind  = 1'b0;
      w_ovf_set = 1'b0;
      w_pop     = rd_en && (w_rd_cnt != '0) && !reg_flush;
      if (!reg_flush) begin
         case (r_state)
            S_IDLE: begin
               w_wr_en   = rx_vld && !w_full;
               w_ovf_set = rx_vld && w_full;
            end
            S_RECV: begin
               w_wr_en   = rx_vld && !w_full;
               w_ovf_set = rx_vld && w_full;
               w_commit  = !rx_vld;
            end
            S_DROP:  w_rewind = !rx_vld;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= rx_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_cm_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_ovf      <= 1'b0;
         r_af       <= 1'b0;
         r_rd_dat   <= '0;
         r_pkt_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_af <= w_af_nxt;
         if (reg_flush) begin
            r_wr_ptr <= '0;
            r_cm_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
         end else begin
            if (w_wr_en) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end else if (w_rewind) begin
               r_wr_ptr <= r_cm_ptr;
            end
            if (w_commit) begin
               r_cm_ptr  <= r_wr_ptr;
               r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
            if (w_ovf_set) begin
               r_ovf <= 1'b1;
            end else if (w_rewind) begin
               r_ovf <= 1'b0;
            end
            // Flush-induced drops leave r_ovf clear, so only real overflows are counted.
            if (w_rewind && r_ovf && (r_drop_cnt != 16'hFFFF)) begin
               r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_pop) begin
               r_rd_dat <= r_mem[r_rd_ptr[AW-1:0]];
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
         end
      end
   end

   assign rx_almost_full = r_af;
   assign rd_dat         = r_rd_dat;
   assign rd_cnt         = w_rd_cnt;
   assign pkt_cnt        = r_pkt_cnt;
   assign drop_cnt       = r_drop_cnt;

endmodule
